// File: rtl/fetch_unit.sv
// fetch_unit: sequential instruction fetch into an in-order fetch buffer, with redirect flush and halt.
// Latency: request issued in cycle N, response written at end of N+1, presented on inst/inst_pc in N+2 (no bypass).
// Backpressure: a request is issued only while buffered + in-flight < BUF_DEPTH, so every response has a free slot.
//
// Ports:
//   clk, rst                     single clock, synchronous active-high reset
//   redirect_valid, redirect_pc  flush buffer, drop in-flight response, restart at word-aligned target
//   halt                         level request to stop issuing fetches (buffer keeps draining)
//   imem_req_valid/addr          read request to instruction memory (always accepted)
//   imem_rsp_valid/data          read response, exactly one cycle after its request
//   inst_valid/ready, inst/pc    buffer head presented to the consumer with a valid/ready handshake
module fetch_unit #(
  parameter int              XLEN      = 64,
  parameter logic [XLEN-1:0] RESET_PC  = '0,
  parameter int              BUF_DEPTH = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  input  logic            halt,
  output logic            imem_req_valid,
  output logic [XLEN-1:0] imem_req_addr,
  input  logic            imem_rsp_valid,
  input  logic [31:0]     imem_rsp_data,
  output logic            inst_valid,
  input  logic            inst_ready,
  output logic [31:0]     inst,
  output logic [XLEN-1:0] inst_pc
);

  localparam int PTR_W = $clog2(BUF_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  typedef enum logic {
    S_FETCH  = 1'b0,
    S_HALTED = 1'b1
  } state_t;

  state_t            r_state;
  state_t            w_state_nxt;
  logic              w_in_fetch;

  logic [XLEN-1:0]   r_fetch_pc;
  logic              r_inflight_vld;
  logic [XLEN-1:0]   r_inflight_pc;

  logic [31:0]       r_buf_inst [BUF_DEPTH];
  logic [XLEN-1:0]   r_buf_pc   [BUF_DEPTH];
  logic [PTR_W-1:0]  r_head;
  logic [PTR_W-1:0]  r_tail;
  logic [CNT_W-1:0]  r_count;

  logic [CNT_W-1:0]  w_used;
  logic              w_credit_ok;
  logic              w_issue;
  logic              w_push;
  logic              w_pop;
  logic              w_head_vld;
  logic [XLEN-1:0]   w_redirect_tgt;

  // ---------------------------------------------------------------------------
  // Fetch/halt FSM: state register, next-state logic, output decode.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_FETCH;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Redirect never changes the state; a redirect while halted stays halted.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_FETCH:  if (halt)  w_state_nxt = S_HALTED;
      S_HALTED: if (!halt) w_state_nxt = S_FETCH;
      default:             w_state_nxt = S_FETCH;
    endcase
  end

  always_comb begin
    w_in_fetch = 1'b0;
    case (r_state)
      S_FETCH: w_in_fetch = 1'b1;
      default: w_in_fetch = 1'b0;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Credit check and handshakes.
  // ---------------------------------------------------------------------------
  // Credit is conservative: a pop in the same cycle does not free a slot for
  // this cycle's request, so a response can never find the buffer full.
  assign w_used      = r_count + CNT_W'(r_inflight_vld);
  assign w_credit_ok = (w_used < CNT_W'(BUF_DEPTH));

  assign w_issue     = !rst && w_in_fetch && !redirect_valid && w_credit_ok;

  // The in-flight tag qualifies the response; a redirect in the response
  // cycle kills it, and reset clears the tag so late responses are ignored.
  assign w_push      = !rst && !redirect_valid && imem_rsp_valid && r_inflight_vld;

  assign w_head_vld  = !rst && (r_count != '0);
  assign w_pop       = w_head_vld && inst_ready;

  // Low two bits masked rather than sliced so the whole target port is consumed.
  assign w_redirect_tgt = redirect_pc & ~XLEN'(3);

  // ---------------------------------------------------------------------------
  // Fetch PC, in-flight tag and buffer pointers.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      r_fetch_pc     <= RESET_PC;
      r_inflight_vld <= 1'b0;
      r_inflight_pc  <= '0;
      r_head         <= '0;
      r_tail         <= '0;
      r_count        <= '0;
    end else if (redirect_valid) begin
      // Flush wins over push and pop; a head handshake this cycle is simply
      // absorbed by the flush.
      r_fetch_pc     <= w_redirect_tgt;
      r_inflight_vld <= 1'b0;
      r_head         <= '0;
      r_tail         <= '0;
      r_count        <= '0;
    end else begin
      r_inflight_vld <= w_issue;
      if (w_issue) begin
        r_inflight_pc <= r_fetch_pc;
        r_fetch_pc    <= r_fetch_pc + XLEN'(4);
      end
      if (w_push) begin
        r_tail <= r_tail + PTR_W'(1);
      end
      if (w_pop) begin
        r_head <= r_head + PTR_W'(1);
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Buffer storage needs no reset: entries are only read while counted valid.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_buf_inst[r_tail] <= imem_rsp_data;
      r_buf_pc[r_tail]   <= r_inflight_pc;
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs.
  // ---------------------------------------------------------------------------
  assign imem_req_valid = w_issue;
  assign imem_req_addr  = r_fetch_pc;

  assign inst_valid     = w_head_vld;
  assign inst           = w_head_vld ? r_buf_inst[r_head] : 32'h0;
  assign inst_pc        = w_head_vld ? r_buf_pc[r_head]   : '0;

endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: directed scenarios followed by randomized traffic, checked each cycle against a queue-based model.
// Latency: one tick() per clock; outputs sampled on the falling edge, model advanced on the rising edge.
// Backpressure: inst_ready driven per scenario; the memory responder answers every request one cycle later.
module tb_fetch_unit;

  localparam int          XLEN   = 64;
  localparam int          DEPTH  = 4;
  localparam logic [63:0] RST_PC = 64'h0;

  logic        clk = 1'b0;
  logic        rst;
  logic        redirect_valid;
  logic [63:0] redirect_pc;
  logic        halt;
  logic        imem_req_valid;
  logic [63:0] imem_req_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        inst_valid;
  logic        inst_ready;
  logic [31:0] inst;
  logic [63:0] inst_pc;

  always #5 clk = ~clk;

  fetch_unit #(
    .XLEN      (XLEN),
    .RESET_PC  (RST_PC),
    .BUF_DEPTH (DEPTH)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .halt           (halt),
    .imem_req_valid (imem_req_valid),
    .imem_req_addr  (imem_req_addr),
    .imem_rsp_valid (imem_rsp_valid),
    .imem_rsp_data  (imem_rsp_data),
    .inst_valid     (inst_valid),
    .inst_ready     (inst_ready),
    .inst           (inst),
    .inst_pc        (inst_pc)
  );

  // Reference model: buffer as a queue of (word, pc), plus fetch pc, halted flag and in-flight tag.
  typedef struct {
    logic [31:0] word;
    logic [63:0] pc;
  } ent_t;

  ent_t        m_q[$];
  logic [63:0] m_pc;
  logic        m_halted;
  logic        m_inflight;
  logic [63:0] m_inflight_pc;

  int checks   = 0;
  int failures = 0;

  // Observations from the most recent tick.
  logic        obs_req;
  logic [63:0] obs_addr;
  logic        obs_vld;
  logic [31:0] obs_inst;
  logic [63:0] obs_ipc;
  logic        hs;
  logic [63:0] last_req_addr;
  bit          mem_rand;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    logic e_req;
    logic e_vld;
    @(negedge clk);
    obs_req  = imem_req_valid;
    obs_addr = imem_req_addr;
    obs_vld  = inst_valid;
    obs_inst = inst;
    obs_ipc  = inst_pc;
    if (rst) begin
      e_req = 1'b0;
      e_vld = 1'b0;
    end else begin
      e_req = !m_halted && !redirect_valid && ((m_q.size() + (m_inflight ? 1 : 0)) < DEPTH);
      e_vld = (m_q.size() != 0);
    end
    chk("req_valid", 64'(obs_req), 64'(e_req));
    if (e_req) chk("req_addr", obs_addr, m_pc);
    chk("inst_valid", 64'(obs_vld), 64'(e_vld));
    if (rst) begin
      chk("inst_in_reset", 64'(obs_inst), 64'h0);
      chk("inst_pc_in_reset", obs_ipc, 64'h0);
    end else if (e_vld) begin
      chk("inst", 64'(obs_inst), 64'(m_q[0].word));
      chk("inst_pc", obs_ipc, m_q[0].pc);
    end
    hs = obs_vld && inst_ready;
    if (obs_req) last_req_addr = obs_addr;

    @(posedge clk);
    if (rst) begin
      m_q.delete();
      m_pc       = RST_PC;
      m_halted   = 1'b0;
      m_inflight = 1'b0;
    end else begin
      if (redirect_valid) begin
        m_q.delete();
        m_pc       = redirect_pc & ~64'h3;
        m_inflight = 1'b0;
      end else begin
        if (e_vld && inst_ready) m_q.delete(0);
        if (imem_rsp_valid && m_inflight) m_q.push_back('{imem_rsp_data, m_inflight_pc});
        if (e_req) begin
          m_inflight_pc = m_pc;
          m_pc          = m_pc + 64'd4;
        end
        m_inflight = e_req;
      end
      m_halted = halt;
    end

    #1;
    // Memory: answers whatever the DUT actually requested, one cycle later.
    imem_rsp_valid = obs_req;
    imem_rsp_data  = mem_rand ? $urandom : 32'h0000_0013;
  endtask

  initial begin
    int          first;
    int          nreq;
    int          k;
    logic [63:0] addrs [3];
    logic [63:0] drained [4];
    logic [63:0] hold_pc;
    logic [31:0] hold_inst;
    logic [63:0] snap;

    rst = 1'b1; redirect_valid = 1'b0; redirect_pc = '0; halt = 1'b0;
    imem_rsp_valid = 1'b0; imem_rsp_data = '0; inst_ready = 1'b1; mem_rand = 1'b0;
    last_req_addr = '0;
    m_q.delete(); m_pc = RST_PC; m_halted = 1'b0; m_inflight = 1'b0; m_inflight_pc = '0;

    // Reset: outputs held at reset values.
    repeat (3) tick();

    // Sequential fetch with 0x13 words, consumer always ready.
    rst   = 1'b0;
    first = -1;
    hold_pc = 64'hdead_beef;
    for (int i = 0; i < 3; i++) addrs[i] = 64'hdead_beef;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (i < 3 && obs_req) addrs[i] = obs_addr;
      if (obs_vld && first < 0) begin
        first   = i;
        hold_pc = obs_ipc;
      end
    end
    chk("first_valid_cycle", 64'(first), 64'd2);
    chk("first_inst_pc", hold_pc, 64'h0);
    for (int i = 0; i < 3; i++) chk("seq_req_addr", addrs[i], 64'(4 * i));

    // Stalled consumer from an empty buffer: exactly DEPTH requests, stable head.
    mem_rand = 1'b1;
    inst_ready = 1'b0; redirect_valid = 1'b1; redirect_pc = 64'h2000;
    tick();
    redirect_valid = 1'b0;
    nreq = 0; k = 0; hold_pc = '0; hold_inst = '0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (obs_req) nreq++;
      if (obs_vld) begin
        if (hold_pc == 64'h0) begin
          hold_pc   = obs_ipc;
          hold_inst = obs_inst;
        end else if (obs_ipc !== hold_pc || obs_inst !== hold_inst) begin
          k++;
        end
      end
    end
    chk("stall_req_count", 64'(nreq), 64'(DEPTH));
    chk("stall_head_pc", hold_pc, 64'h2000);
    chk("stall_head_changes", 64'(k), 64'd0);
    chk("stall_still_valid", 64'(obs_vld), 64'd1);

    // Drain in order.
    inst_ready = 1'b1;
    k = 0;
    for (int i = 0; i < 4; i++) drained[i] = 64'hdead_beef;
    for (int i = 0; i < 8 && k < 4; i++) begin
      tick();
      if (hs) begin
        drained[k] = obs_ipc;
        k++;
      end
    end
    for (int i = 0; i < 4; i++) chk("drain_order", drained[i], 64'h2000 + 64'(4 * i));

    // Redirect with three buffered entries and one response in flight.
    inst_ready = 1'b0; redirect_valid = 1'b1; redirect_pc = 64'h3000;
    tick();
    redirect_valid = 1'b0;
    repeat (4) tick();
    redirect_valid = 1'b1; redirect_pc = 64'h1002;
    tick();
    redirect_valid = 1'b0;
    chk("pre_redirect_valid", 64'(obs_vld), 64'd1);
    chk("pre_redirect_head", obs_ipc, 64'h3000);
    inst_ready = 1'b1;
    tick();
    chk("flush_empty", 64'(obs_vld), 64'd0);
    chk("redirect_req", 64'(obs_req), 64'd1);
    chk("redirect_addr", obs_addr, 64'h1000);
    tick();
    chk("stale_dropped", 64'(obs_vld), 64'd0);
    tick();
    chk("redirect_head_valid", 64'(obs_vld), 64'd1);
    chk("redirect_head_pc", obs_ipc, 64'h1000);

    // Halt for five cycles, then resume at the next sequential pc.
    halt = 1'b1;
    nreq = 0;
    for (int i = 0; i < 5; i++) begin
      tick();
      if (i > 0 && obs_req) nreq++;
    end
    chk("halt_no_req", 64'(nreq), 64'd0);
    chk("halt_drained", 64'(obs_vld), 64'd0);
    snap = last_req_addr;
    halt = 1'b0;
    tick();
    chk("unhalt_wait", 64'(obs_req), 64'd0);
    tick();
    chk("resume_req", 64'(obs_req), 64'd1);
    chk("resume_addr", obs_addr, snap + 64'd4);

    // Address wrap at the top of the address space.
    redirect_valid = 1'b1; redirect_pc = 64'hFFFF_FFFF_FFFF_FFFE;
    tick();
    redirect_valid = 1'b0;
    tick();
    chk("wrap_top_addr", obs_addr, 64'hFFFF_FFFF_FFFF_FFFC);
    tick();
    chk("wrap_req", 64'(obs_req), 64'd1);
    chk("wrap_zero_addr", obs_addr, 64'h0);

    // Reset with a response in flight.
    tick();
    chk("pre_reset_req", 64'(obs_req), 64'd1);
    rst = 1'b1;
    tick();
    chk("reset_no_req", 64'(obs_req), 64'd0);
    chk("reset_no_valid", 64'(obs_vld), 64'd0);
    tick();
    rst = 1'b0;
    tick();
    chk("restart_req", 64'(obs_req), 64'd1);
    chk("restart_addr", obs_addr, RST_PC);
    tick();
    chk("restart_not_yet_valid", 64'(obs_vld), 64'd0);
    tick();
    chk("restart_head_valid", 64'(obs_vld), 64'd1);
    chk("restart_head_pc", obs_ipc, RST_PC);

    // Randomized traffic: ready, halt, redirects and occasional resets.
    for (int i = 0; i < 1500; i++) begin
      inst_ready     = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 15) == 0) halt = ~halt;
      redirect_valid = ($urandom_range(0, 19) == 0);
      redirect_pc    = {$urandom, $urandom};
      rst            = ($urandom_range(0, 199) == 0);
      tick();
    end
    rst = 1'b0; halt = 1'b0; redirect_valid = 1'b0; inst_ready = 1'b1;
    repeat (4) tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 SHALL have parameter XLEN, default 64, meaning PC and address width.
REQ-002 SHALL have parameter RESET_PC, default 0, meaning first fetch address after reset.
REQ-003 SHALL have parameter BUF_DEPTH, default 4, meaning fetch-buffer entries; power of two, at least 2.
REQ-004 SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-005 SHALL have port rst, input, 1, synchronous active-high reset.
REQ-006 SHALL have port redirect_valid, input, 1, branch/jump redirect strobe.
REQ-007 SHALL have port redirect_pc, input, XLEN, redirect target.
REQ-008 SHALL have port halt, input, 1, level request to stop issuing fetches.
REQ-009 SHALL have port imem_req_valid, output, 1, memory read request.
REQ-010 SHALL have port imem_req_addr, output, XLEN, request address.
REQ-011 SHALL have port imem_rsp_valid, input, 1, response strobe, exactly 1 cycle after request.
REQ-012 SHALL have port imem_rsp_data, input, 32, fetched instruction word.
REQ-013 SHALL have port inst_valid, output, 1, buffer head valid.
REQ-014 SHALL have port inst_ready, input, 1, consumer accepts head.
REQ-015 SHALL have port inst, output, 32, head instruction.
REQ-016 SHALL have port inst_pc, output, XLEN, address of head instruction.

Function
REQ-017 SHALL implement FSM states FETCH and HALTED; FETCH->HALTED when halt=1, HALTED->FETCH when halt=0, transitions taking effect next cycle.
REQ-018 SHALL assert imem_req_valid only in FETCH when (buffer count + in-flight) < BUF_DEPTH, with imem_req_addr = fetch_pc.
REQ-019 SHALL advance fetch_pc by 4 per issued request, wrapping modulo 2^XLEN.
REQ-020 SHALL memory always accept requests; one in-flight tag tracks the PC of the outstanding request.
REQ-021 SHALL write imem_rsp_data and its PC into the buffer tail at the end of the response cycle unless killed; inst_valid rises the following cycle (fetch-to-output latency 2 cycles, no bypass).
REQ-022 SHALL pop the head when inst_valid and inst_ready are both 1; push and pop in the same cycle SHALL leave count unchanged.
REQ-023 SHALL hold inst and inst_pc stable while inst_valid=1 and inst_ready=0.
REQ-024 SHALL never overflow: credit check in REQ-018 guarantees a free entry for every response.
REQ-025 SHALL, on redirect_valid=1: empty the buffer, kill any in-flight response (dropped when it arrives, even in the same cycle), set fetch_pc = {redirect_pc[XLEN-1:2],2'b00}; no request issued in the redirect cycle.
REQ-026 SHALL treat a head handshake in the redirect cycle as completed; redirect has priority over push.
REQ-027 SHALL, in HALTED, issue no requests, still accept a pending in-flight response, and keep draining the buffer.
REQ-028 SHALL apply redirect while HALTED by updating fetch_pc and flushing, remaining HALTED.
REQ-029 SHALL assert inst_valid=0 when count=0 regardless of inst_ready.

Reset
REQ-030 SHALL, while rst=1: fetch_pc=RESET_PC, state FETCH, count=0, no in-flight, imem_req_valid=0, inst_valid=0, inst=0, inst_pc=0.
REQ-031 SHALL issue the first request at RESET_PC in the first cycle after rst falls.
REQ-032 SHALL discard any in-flight response when rst is asserted mid-operation.

Verification
REQ-033 SHALL verify: rst low, inst_ready=1, memory returns 0x00000013 -> req addrs 0x0,0x4,0x8..., inst_valid first high 2 cycles after rst falls with inst_pc=0x0.
REQ-034 SHALL verify: inst_ready=0 for 10 cycles -> exactly BUF_DEPTH requests issued, inst/inst_pc stable, no overflow; ready=1 then drains in order.
REQ-035 SHALL verify: redirect_valid with redirect_pc=0x1002 while buffer holds 3 entries and one in flight -> buffer empty next cycle, stale response dropped, next req addr 0x1000.
REQ-036 SHALL verify: halt=1 for 5 cycles -> no requests after the transition cycle, buffer drains, fetch resumes at the next sequential PC after halt=0.
REQ-037 SHALL verify: fetch_pc at 2^XLEN-4 -> next request address 0x0.
REQ-038 SHALL verify: rst asserted with response in flight -> response ignored, all outputs at reset values, restart at RESET_PC.
